fb_ports: RTL and testbench
===========================

FB_PORTS -- requirements
Module: fb_ports

Interface
REQ-001 Parameter WIDTH, default 320, pixels per line.
REQ-002 Parameter HEIGHT, default 240, lines per frame.
REQ-003 Parameter BPP, default 1, bits per pixel (1..8).
REQ-004 Parameter XW, default 9, x coordinate width; parameter YW, default 8, y coordinate width.
REQ-005 clk  input  1  single clock for all logic and the pixel array.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 disp_en  input  1  display read strobe.
REQ-008 disp_x / disp_y  input  XW / YW  display pixel coordinate.
REQ-009 disp_pix  output  BPP  display pixel value.
REQ-010 disp_valid  output  1  disp_pix is valid.
REQ-011 req_valid  input  1  client request present.
REQ-012 req_op  input  2  00 read, 01 write, 10 xor, 11 clear.
REQ-013 req_x / req_y  input  XW / YW  client coordinate (ignored for clear).
REQ-014 req_data  input  BPP  write, xor or clear value.
REQ-015 req_ready  output  1  block accepts a request this cycle.
REQ-016 rsp_valid  output  1  one-cycle completion pulse.
REQ-017 rsp_data  output  BPP  pixel value before the op (read/xor), else 0.
REQ-018 rsp_err  output  1  coordinate out of range, qualified by rsp_valid.

Function
REQ-019 Array holds WIDTH*HEIGHT pixels of BPP bits, linear address = x + y*WIDTH, inferred true dual-port, display port read-only.
REQ-020 Request accepted on the clk edge where req_valid && req_ready; req_* are captured at that edge; cycle N is the acceptance cycle.
REQ-021 req_ready = 1 only in state IDLE; every accepted op yields exactly one rsp_valid pulse.
REQ-022 States: IDLE, RD_WAIT, RD_OUT, WR, XR_WAIT, XR_WR, CLEAR.
REQ-023 Read: IDLE->RD_WAIT (N+1)->RD_OUT (N+2, rsp_valid=1, rsp_data=pixel)->IDLE (N+3).
REQ-024 Write: IDLE->WR (N+1, array written at end of N+1, rsp_valid=1)->IDLE (N+2).
REQ-025 Xor: IDLE->XR_WAIT (N+1)->XR_WR (N+2, writes old^req_data, rsp_valid=1, rsp_data=old)->IDLE (N+3).
REQ-026 Clear: IDLE->CLEAR for WIDTH*HEIGHT cycles writing addresses 0..WIDTH*HEIGHT-1 in order with req_data; rsp_valid on the last write cycle; then IDLE.
REQ-027 Out of range (x>=WIDTH or y>=HEIGHT): same state sequence and timing, array not modified, rsp_data=0, rsp_err=1.
REQ-028 rsp_valid, rsp_err, rsp_data are 0 whenever not in a completion cycle.
REQ-029 Address arithmetic sized to hold WIDTH*HEIGHT-1 without truncation; clear counter stops at last address, no wrap.
REQ-030 Display latency 2: disp_en/x/y at cycle M -> disp_valid=1, disp_pix at M+2; disp_valid=0 otherwise; disp_pix holds last value when disp_en low.
REQ-031 Display out of range -> disp_pix=0 with disp_valid=1.
REQ-032 Display read and client write to same address in same cycle return old data (read-first); display port never stalls the client port and vice versa.
REQ-033 req_valid while req_ready=0 is ignored; requester must hold it until accepted.

Reset
REQ-034 reset_n low forces state IDLE, req_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_data=0, disp_valid=0, disp_pix=0, clear counter=0, display pipeline flushed.
REQ-035 Array contents are not cleared by reset; reset during CLEAR aborts it with no rsp_valid, already-written pixels keep req_data.
REQ-036 Reset during RD/WR/XR states drops the op with no response; a write in WR at the reset edge may or may not land.

Verification
REQ-037 BPP=2: write (5,3)=2'b10 -> rsp_valid at N+1, rsp_err=0; read (5,3) -> rsp_valid at N+2, rsp_data=2'b10.
REQ-038 BPP=2, pixel (0,0)=2'b01, xor req_data=2'b11 -> rsp_data=2'b01 at N+2; later read -> 2'b10.
REQ-039 WIDTH=8 HEIGHT=4: clear with 1 -> req_ready low 32 cycles, rsp_valid on 32nd, display scan of all pixels returns 1.
REQ-040 Read (320,0) and write (0,240) at defaults -> rsp_err=1, rsp_data=0, adjacent pixels (319,0),(0,239) unchanged.
REQ-041 Display reads (7,1) same cycle client writes (7,1): disp_pix two cycles later = old value; next display read = new value.
REQ-042 Assert reset_n low mid-CLEAR at pixel 10 -> outputs zero immediately, after release req_ready=1, pixels 0..9 new, 10.. old.

Source files
------------

// File: rtl/fb_ports.sv
// Dual-port pixel framebuffer: a client port serialising read/write/xor/clear ops through a small
// FSM, and an independent read-only display port with two-cycle latency.
module fb_ports #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned BPP    = 1,
    parameter int unsigned XW     = 9,
    parameter int unsigned YW     = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            disp_en,
    input  logic [XW-1:0]   disp_x,
    input  logic [YW-1:0]   disp_y,
    output logic [BPP-1:0]  disp_pix,
    output logic            disp_valid,
    input  logic            req_valid,
    input  logic [1:0]      req_op,
    input  logic [XW-1:0]   req_x,
    input  logic [YW-1:0]   req_y,
    input  logic [BPP-1:0]  req_data,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [BPP-1:0]  rsp_data,
    output logic            rsp_err
);

    localparam int unsigned DEPTH = WIDTH * HEIGHT;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRdWait = 3'd1;
    localparam logic [2:0] StRdOut  = 3'd2;
    localparam logic [2:0] StWr     = 3'd3;
    localparam logic [2:0] StXrWait = 3'd4;
    localparam logic [2:0] StXrWr   = 3'd5;
    localparam logic [2:0] StClear  = 3'd6;

    logic [2:0]     state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [BPP-1:0] data_q, data_d;
    logic           err_q, err_d;
    logic [AW-1:0]  cnt_q, cnt_d;

    logic [BPP-1:0] mem [DEPTH];
    logic [BPP-1:0] rd_q;
    logic [BPP-1:0] disp_rd_q;

    logic           mem_we;
    logic [AW-1:0]  mem_wa;
    logic [BPP-1:0] mem_wd;

    logic           req_in_range;
    logic [AW-1:0]  req_addr;
    logic           disp_in_range;
    logic [AW-1:0]  disp_addr;

    logic           dv1_q;
    logic           din1_q;
    logic           disp_valid_q;
    logic [BPP-1:0] disp_pix_q;

    assign req_in_range  = (32'(req_x) < WIDTH) && (32'(req_y) < HEIGHT);
    assign req_addr      = AW'(req_x) + AW'(req_y) * AW'(WIDTH);
    assign disp_in_range = (32'(disp_x) < WIDTH) && (32'(disp_y) < HEIGHT);
    // Out-of-range coordinates are steered to address 0 so the array is never indexed past DEPTH.
    assign disp_addr     = disp_in_range ? AW'(disp_x) + AW'(disp_y) * AW'(WIDTH) : '0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d = req_in_range ? req_addr : '0;
                    data_d = req_data;
                    err_d  = !req_in_range && (req_op != 2'b11);
                    cnt_d  = '0;
                    unique case (req_op)
                        2'b00:   state_d = StRdWait;
                        2'b01:   state_d = StWr;
                        2'b10:   state_d = StXrWait;
                        default: state_d = StClear;
                    endcase
                end
            end
            StRdWait: state_d = StRdOut;
            StRdOut:  state_d = StIdle;
            StWr:     state_d = StIdle;
            StXrWait: state_d = StXrWr;
            StXrWr:   state_d = StIdle;
            StClear: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = addr_q;
        mem_wd = data_q;
        unique case (state_q)
            StWr:    mem_we = !err_q;
            StXrWr: begin
                mem_we = !err_q;
                mem_wd = rd_q ^ data_q;
            end
            StClear: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
            end
            default: mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Both reads sample the pre-write contents, giving read-first behaviour on a collision.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
        rd_q      <= mem[addr_q];
        disp_rd_q <= mem[disp_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dv1_q        <= 1'b0;
            din1_q       <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_pix_q   <= '0;
        end else begin
            dv1_q        <= disp_en;
            din1_q       <= disp_in_range;
            disp_valid_q <= dv1_q;
            if (dv1_q) begin
                disp_pix_q <= din1_q ? disp_rd_q : '0;
            end
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_pix   = disp_pix_q;

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StRdOut) || (state_q == StWr) || (state_q == StXrWr) ||
                       ((state_q == StClear) && (cnt_q == LAST_ADDR));
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_data  = (((state_q == StRdOut) || (state_q == StXrWr)) && !err_q) ? rd_q : '0;

endmodule

// File: tb/tb_fb_ports.sv
// Randomised bench for fb_ports on a small 8x4, 2-bpp frame, checked against an array model.
module tb_fb_ports;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int N   = W * H;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       disp_en;
    logic [3:0] disp_x;
    logic [2:0] disp_y;
    logic [1:0] disp_pix;
    logic       disp_valid;
    logic       req_valid;
    logic [1:0] req_op;
    logic [3:0] req_x;
    logic [2:0] req_y;
    logic [1:0] req_data;
    logic       req_ready;
    logic       rsp_valid;
    logic [1:0] rsp_data;
    logic       rsp_err;

    logic [1:0] model [N];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_ports #(.WIDTH(W), .HEIGHT(H), .BPP(2), .XW(4), .YW(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .disp_en    (disp_en),
        .disp_x     (disp_x),
        .disp_y     (disp_y),
        .disp_pix   (disp_pix),
        .disp_valid (disp_valid),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input int x, input int y);
        return (x < W) && (y < H);
    endfunction

    // One client op end to end: latency, idle-cycle zeros, response contents, then model update.
    task automatic do_op(input logic [1:0] op, input int x, input int y, input logic [1:0] d);
        int lat;
        bit ok;
        int a;
        logic [1:0] exp_data;
        logic exp_err;
        ok  = in_range(x, y);
        a   = ok ? x + y * W : 0;
        lat = (op == 2'd1) ? 1 : (op == 2'd3) ? N : 2;
        exp_err  = (op != 2'd3) && !ok;
        exp_data = ((op == 2'd0 || op == 2'd2) && ok) ? model[a] : 2'd0;
        @(negedge clk);
        check("req_ready_before", {31'd0, req_ready}, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_x     = 4'(x);
        req_y     = 3'(y);
        req_data  = d;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k < lat) begin
                check("rsp_idle_zero", {28'd0, rsp_valid, rsp_err, rsp_data}, 0);
                check("req_ready_busy", {31'd0, req_ready}, 0);
            end else begin
                check("rsp_valid", {31'd0, rsp_valid}, 1);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
                check("rsp_data", {30'd0, rsp_data}, {30'd0, exp_data});
            end
            @(negedge clk);
        end
        check("req_ready_after", {31'd0, req_ready}, 1);
        check("rsp_after_zero", {28'd0, rsp_valid, rsp_err, rsp_data}, 0);
        if (op == 2'd1 && ok) model[a] = d;
        if (op == 2'd2 && ok) model[a] = model[a] ^ d;
        if (op == 2'd3) for (int i = 0; i < N; i++) model[i] = d;
    endtask

    task automatic disp_chk(input int x, input int y);
        logic [1:0] exp;
        exp = in_range(x, y) ? model[x + y * W] : 2'd0;
        @(negedge clk);
        disp_en = 1'b1;
        disp_x  = 4'(x);
        disp_y  = 3'(y);
        @(negedge clk);
        disp_en = 1'b0;
        check("disp_valid_early", {31'd0, disp_valid}, 0);
        @(negedge clk);
        check("disp_valid", {31'd0, disp_valid}, 1);
        check("disp_pix", {30'd0, disp_pix}, {30'd0, exp});
    endtask

    initial begin
        logic [1:0] old_v;
        logic [1:0] new_v;
        reset_n   = 1'b0;
        disp_en   = 1'b0;
        disp_x    = '0;
        disp_y    = '0;
        req_valid = 1'b0;
        req_op    = '0;
        req_x     = '0;
        req_y     = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {26'd0, rsp_valid, rsp_err, rsp_data, disp_valid, disp_pix}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 1);

        // Clear with 1, then scan the whole frame through the display port.
        do_op(2'd3, 0, 0, 2'd1);
        for (int i = 0; i < N; i++) disp_chk(i % W, i / W);

        do_op(2'd1, 5, 3, 2'b10);
        do_op(2'd0, 5, 3, 2'b00);
        do_op(2'd1, 0, 0, 2'b01);
        do_op(2'd2, 0, 0, 2'b11);
        do_op(2'd0, 0, 0, 2'b00);
        check("xor_result_model", {30'd0, model[0]}, 2);

        // Out-of-range ops must not touch their in-range neighbours.
        do_op(2'd1, 7, 0, 2'd2);
        do_op(2'd1, 0, 3, 2'd3);
        do_op(2'd0, 8, 0, 2'd0);
        do_op(2'd1, 0, 4, 2'd1);
        do_op(2'd2, 15, 7, 2'd3);
        do_op(2'd0, 7, 0, 2'd0);
        do_op(2'd0, 0, 3, 2'd0);
        disp_chk(8, 0);
        disp_chk(0, 4);

        // Display read of (7,1) on the same edge the client write lands.
        old_v = model[7 + W];
        new_v = ~old_v;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_x     = 4'd7;
        req_y     = 3'd1;
        req_data  = new_v;
        @(negedge clk);
        req_valid = 1'b0;
        check("collide_wr_rsp", {31'd0, rsp_valid}, 1);
        disp_en = 1'b1;
        disp_x  = 4'd7;
        disp_y  = 3'd1;
        @(negedge clk);
        disp_en = 1'b0;
        @(negedge clk);
        check("collide_valid", {31'd0, disp_valid}, 1);
        check("collide_old", {30'd0, disp_pix}, {30'd0, old_v});
        model[7 + W] = new_v;
        @(negedge clk);
        check("disp_valid_drop", {31'd0, disp_valid}, 0);
        check("disp_pix_hold", {30'd0, disp_pix}, {30'd0, old_v});
        disp_chk(7, 1);

        for (int n = 0; n < 80; n++) begin
            int op;
            op = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
            do_op(2'(op), $urandom_range(0, 9), $urandom_range(0, 4), 2'($urandom_range(0, 3)));
            if ((n % 4) == 0) disp_chk($urandom_range(0, 9), $urandom_range(0, 4));
        end

        // Reset part way through a clear: pixels 0..9 take the new value, the rest keep the old.
        do_op(2'd3, 0, 0, 2'd0);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd3;
        req_data  = 2'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {26'd0, rsp_valid, rsp_err, rsp_data, disp_valid, disp_pix}, 0);
        for (int i = 0; i < 10; i++) model[i] = 2'd3;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_rsp", {31'd0, rsp_valid}, 0);
            check("abort_ready", {31'd0, req_ready}, 1);
        end
        for (int i = 0; i < N; i++) disp_chk(i % W, i / W);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
